// File: rtl/divide_imag.sv
// Registered image tiler: cuts a SIZE x SIZE image into NT*NT tiles of
// FILTER_SIZE x FILTER_SIZE pixels and presents all tiles one cycle after capture.
module divide_imag #(
    parameter int SIZE        = 9,
    parameter int FILTER_SIZE = 3,
    localparam int NT         = SIZE / FILTER_SIZE,
    localparam int NCH        = NT * NT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] array1 [0:SIZE-1][0:SIZE-1],
    output logic [31:0] array2 [0:NCH-1][0:FILTER_SIZE-1][0:FILTER_SIZE-1],
    output logic        valid
);

    logic [31:0] tiled_s [0:NCH-1][0:FILTER_SIZE-1][0:FILTER_SIZE-1];

    // Pure rewiring: tile ch covers rows (ch/NT)*F.. and cols (ch%NT)*F..;
    // leftover rows/cols beyond NT*FILTER_SIZE are never referenced.
    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        for (genvar i = 0; i < FILTER_SIZE; i++) begin : g_row
            for (genvar j = 0; j < FILTER_SIZE; j++) begin : g_col
                assign tiled_s[ch][i][j] =
                    array1[(ch / NT) * FILTER_SIZE + i][(ch % NT) * FILTER_SIZE + j];
            end
        end
    end

    // Capture register: loads all tiles on en, holds otherwise; reset clears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            array2 <= '{default: '{default: '{default: 32'd0}}};
            valid  <= 1'b0;
        end else begin
            valid <= en;
            if (en) begin
                array2 <= tiled_s;
            end else begin
                array2 <= array2;
            end
        end
    end

endmodule

// File: tb/tb_divide_imag.sv
// Directed self-checking bench for divide_imag at SIZE=9 and the
// non-divisible SIZE=10 case, both with FILTER_SIZE=3.
module tb_divide_imag;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [31:0] a1 [0:8][0:8];
    logic [31:0] a2 [0:8][0:2][0:2];
    logic        valid_a;
    logic [31:0] b1 [0:9][0:9];
    logic [31:0] b2 [0:8][0:2][0:2];
    logic        valid_b;

    // Image expected to be present in a2 (bench's own copy).
    logic [31:0] cap [0:8][0:8];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    divide_imag #(.SIZE(9), .FILTER_SIZE(3)) dut_a (
        .clk(clk), .reset(reset), .en(en), .array1(a1), .array2(a2), .valid(valid_a)
    );

    divide_imag #(.SIZE(10), .FILTER_SIZE(3)) dut_b (
        .clk(clk), .reset(reset), .en(en), .array1(b1), .array2(b2), .valid(valid_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_img(input logic [31:0] base);
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                a1[r][c] = base + 32'(r * 16 + c);
    endtask

    task automatic snap;
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                cap[r][c] = a1[r][c];
    endtask

    // Compare every tile element against the expected image via the tiling formula.
    task automatic check_tiles(input string tag);
        for (int ch = 0; ch < 9; ch++)
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    chk($sformatf("%s[%0d][%0d][%0d]", tag, ch, i, j),
                        a2[ch][i][j], cap[(ch / 3) * 3 + i][(ch % 3) * 3 + j]);
    endtask

    task automatic check_zero(input string tag);
        for (int ch = 0; ch < 9; ch++)
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) begin
                    chk($sformatf("%s_a[%0d][%0d][%0d]", tag, ch, i, j), a2[ch][i][j], 32'd0);
                    chk($sformatf("%s_b[%0d][%0d][%0d]", tag, ch, i, j), b2[ch][i][j], 32'd0);
                end
        chk({tag, "_valid_a"}, {31'd0, valid_a}, 32'd0);
        chk({tag, "_valid_b"}, {31'd0, valid_b}, 32'd0);
    endtask

    initial begin
        logic [31:0] v;

        // Reset held while clocking with all-3 image and en=1.
        reset = 1'b1;
        en    = 1'b1;
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                a1[r][c] = 32'd3;
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++)
                b1[r][c] = 32'(r * 16 + c);
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_hold");

        // Uniform fill: one capture of all-3.
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int ch = 0; ch < 9; ch++)
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    chk($sformatf("uniform[%0d][%0d][%0d]", ch, i, j), a2[ch][i][j], 32'd3);
        chk("uniform_valid", {31'd0, valid_a}, 32'd1);

        // Mapping with r*16+c pattern.
        @(negedge clk);
        set_img(32'd0);
        snap();
        @(posedge clk);
        #1;
        chk("map_0_0_0", a2[0][0][0], 32'h00);
        chk("map_4_1_2", a2[4][1][2], 32'h45);
        chk("map_8_2_2", a2[8][2][2], 32'h88);
        chk("map_5_0_0", a2[5][0][0], 32'h36);
        chk("map_1_2_0", a2[1][2][0], 32'h23);
        check_tiles("map");
        chk("map_valid", {31'd0, valid_a}, 32'd1);

        // Non-divisible SIZE=10: row 9 / col 9 never appear.
        chk("nd_8_2_2", b2[8][2][2], 32'h88);
        chk("nd_0_1_1", b2[0][1][1], 32'h11);
        chk("nd_valid", {31'd0, valid_b}, 32'd1);
        for (int ch = 0; ch < 9; ch++)
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) begin
                    v = b2[ch][i][j];
                    chk($sformatf("nd_row9[%0d][%0d][%0d]", ch, i, j),
                        {31'd0, v[7:4] == 4'd9 || v[3:0] == 4'd9}, 32'd0);
                end

        // Hold: en=0, new pattern B, two edges -> still pattern A.
        @(negedge clk);
        en = 1'b0;
        set_img(32'hA000_0000);
        repeat (2) @(posedge clk);
        #1;
        check_tiles("hold");
        chk("hold_valid", {31'd0, valid_a}, 32'd0);
        chk("hold_valid_b", {31'd0, valid_b}, 32'd0);

        @(negedge clk);
        en = 1'b1;
        snap();
        @(posedge clk);
        #1;
        chk("reen_4_1_2", a2[4][1][2], 32'hA000_0045);
        check_tiles("reen");
        chk("reen_valid", {31'd0, valid_a}, 32'd1);

        // Back-to-back: new image each cycle, output lags exactly one cycle.
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            set_img(32'(k) << 8);
            chk($sformatf("b2b_pre%0d", k), a2[8][2][2], cap[8][8]);
            snap();
            @(posedge clk);
            #1;
            chk($sformatf("b2b_0_0_0_%0d", k), a2[0][0][0], 32'(k) << 8);
            chk($sformatf("b2b_8_2_2_%0d", k), a2[8][2][2], (32'(k) << 8) + 32'h88);
            chk($sformatf("b2b_5_0_0_%0d", k), a2[5][0][0], (32'(k) << 8) + 32'h36);
            chk($sformatf("b2b_valid%0d", k), {31'd0, valid_a}, 32'd1);
        end

        // Async reset mid-cycle: outputs drop with no clock edge.
        #2;
        reset = 1'b1;
        #1;
        check_zero("async_rst");

        // Reset coincident with a capturing edge: reset wins.
        @(posedge clk);
        #1;
        check_zero("rst_edge");

        // First capture after reset release.
        @(negedge clk);
        reset = 1'b0;
        set_img(32'h5500_0000);
        snap();
        @(posedge clk);
        #1;
        check_tiles("post_rst");
        chk("post_rst_valid", {31'd0, valid_a}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
